// File: rtl/bcd_count_source_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_count_source_if
// Description : Control/preset inputs and BCD digit outputs of the counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_count_source_if;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       tick;
    logic       wrap;

    modport master (
        output en, up, load, load_tens, load_ones,
        input  tens, ones, tick, wrap
    );

    modport slave (
        input  en, up, load, load_tens, load_ones,
        output tens, ones, tick, wrap
    );
endinterface
`default_nettype wire

// File: rtl/bcd_count_source.sv
`default_nettype none
// ============================================================================
// Module      : bcd_count_source
// Description : Prescaled two-digit BCD up/down counter with wrap and preset.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_count_source #(
    parameter int CLK_DIV   = 50_000_000,
    parameter int MAX_COUNT = 99
) (
    input  logic               clk,
    input  logic               rst,
    bcd_count_source_if.slave  bus
);

    localparam int                 c_PRE_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_DIV - 1);
    // Wrap point split into digits once at elaboration; runtime math stays per-digit.
    localparam logic [3:0]         c_MAX_TENS = 4'(MAX_COUNT / 10);
    localparam logic [3:0]         c_MAX_ONES = 4'(MAX_COUNT % 10);

    logic [c_PRE_W-1:0] r_pre;
    logic [3:0]         r_tens;
    logic [3:0]         r_ones;
    logic               r_tick;
    logic               r_wrap;

    logic               w_step;
    logic               w_at_max;
    logic               w_at_zero;
    logic               w_load_ok;
    logic [3:0]         w_nxt_tens;
    logic [3:0]         w_nxt_ones;
    logic               w_wrap;

    assign w_step    = bus.en && !bus.load && (r_pre == c_PRE_LAST);
    assign w_at_max  = (r_tens == c_MAX_TENS) && (r_ones == c_MAX_ONES);
    assign w_at_zero = (r_tens == 4'd0) && (r_ones == 4'd0);
    assign w_load_ok = (bus.load_tens <= 4'd9) && (bus.load_ones <= 4'd9) &&
                       ((bus.load_tens < c_MAX_TENS) ||
                        ((bus.load_tens == c_MAX_TENS) && (bus.load_ones <= c_MAX_ONES)));

    always_comb begin
        w_nxt_tens = r_tens;
        w_nxt_ones = r_ones;
        w_wrap     = 1'b0;
        if (bus.up) begin
            if (w_at_max) begin
                w_nxt_tens = 4'd0;
                w_nxt_ones = 4'd0;
                w_wrap     = 1'b1;
            end else if (r_ones == 4'd9) begin
                w_nxt_tens = r_tens + 4'd1;
                w_nxt_ones = 4'd0;
            end else begin
                w_nxt_ones = r_ones + 4'd1;
            end
        end else begin
            if (w_at_zero) begin
                w_nxt_tens = c_MAX_TENS;
                w_nxt_ones = c_MAX_ONES;
                w_wrap     = 1'b1;
            end else if (r_ones == 4'd0) begin
                w_nxt_tens = r_tens - 4'd1;
                w_nxt_ones = 4'd9;
            end else begin
                w_nxt_ones = r_ones - 4'd1;
            end
        end
    end

    // Prescaler restarts on load so a preset always gets a full interval.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
        end else if (bus.load) begin
            r_pre <= '0;
        end else if (bus.en) begin
            if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + c_PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_tick <= w_step;
            r_wrap <= w_step && w_wrap;
            if (bus.load) begin
                if (w_load_ok) begin
                    r_tens <= bus.load_tens;
                    r_ones <= bus.load_ones;
                end
            end else if (w_step) begin
                r_tens <= w_nxt_tens;
                r_ones <= w_nxt_ones;
            end
        end
    end

    assign bus.tens = r_tens;
    assign bus.ones = r_ones;
    assign bus.tick = r_tick;
    assign bus.wrap = r_wrap;

endmodule
`default_nettype wire
